axi4_rr_arbiter: RTL and testbench

- N-master to 1-slave AXI4 interconnect arbiter.
- Round-robin arbitration on the AW and AR channels independently.
- Routes B/R responses back to the originating master using master-index bits prepended to the transaction ID.
- Sits between CPU/DMA masters and a single memory or peripheral fabric port.

---
 rtl/axi4_arb_pkg.sv | 52 +++++
 rtl/axi4_rr_sel.sv | 24 ++
 rtl/axi4_rr_arbiter.sv | 272 +++++++++++++++++++++++++++
 tb/tb_axi4_rr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_arb_pkg
// Description : Shared types and helpers for the AXI4 round-robin arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package axi4_arb_pkg;

    localparam int c_rr_max = 8;

    typedef enum logic [1:0] {
        AW_IDLE  = 2'd0,
        AW_GRANT = 2'd1,
        W_BURST  = 2'd2
    } aw_state_t;

    typedef enum logic [0:0] {
        AR_IDLE  = 1'b0,
        AR_GRANT = 1'b1
    } ar_state_t;

    // Master index field is never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int slave_id_width(input int id_w, input int idx_w);
        return id_w + idx_w;
    endfunction

    // First requester at or after ptr, wrapping modulo n.
    function automatic int rr_pick(input logic [c_rr_max-1:0] req, input int ptr, input int n);
        int  gnt;
        int  idx;
        bit  found;
        gnt   = 0;
        found = 1'b0;
        for (int k = 0; k < c_rr_max; k++) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (!found && req[idx[2:0]]) begin
                    found = 1'b1;
                    gnt   = idx;
                end
            end
        end
        return gnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_rr_sel.sv
`default_nettype none
// ============================================================================
// Module      : axi4_rr_sel
// Description : Combinational round-robin selector (request vector + pointer).
// Revision    : 1.0  initial release
// ============================================================================
module axi4_rr_sel
    import axi4_arb_pkg::*;
#(
    parameter int N_MASTERS    = 2,
    parameter int MASTER_IDX_W = 1
)(
    input  logic [N_MASTERS-1:0]    i_req,
    input  logic [MASTER_IDX_W-1:0] i_ptr,
    output logic [MASTER_IDX_W-1:0] o_grant,
    output logic                    o_valid
);

    assign o_grant = MASTER_IDX_W'(rr_pick(c_rr_max'(i_req), int'(i_ptr), N_MASTERS));
    assign o_valid = |i_req;

endmodule

`default_nettype wire

// File: rtl/axi4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi4_rr_arbiter
// Description : N-master to 1-slave AXI4 arbiter, independent round-robin on
//               AW and AR, responses routed by master index prefixed to ID.
// Revision    : 1.0  initial release
// ============================================================================
module axi4_rr_arbiter
    import axi4_arb_pkg::*;
#(
    parameter int N_MASTERS          = 2,
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 128,
    parameter int AXI4_ID_WIDTH      = 4,
    parameter int MASTER_IDX_W       = idx_width(N_MASTERS),
    localparam int SID_W             = slave_id_width(AXI4_ID_WIDTH, MASTER_IDX_W)
)(
    input  logic                                              clk,
    input  logic                                              rstn,
    // upstream masters
    input  logic [N_MASTERS-1:0][AXI4_ID_WIDTH-1:0]           i_m_awid,
    input  logic [N_MASTERS-1:0][AXI4_ADDRESS_WIDTH-1:0]      i_m_awaddr,
    input  logic [N_MASTERS-1:0][7:0]                         i_m_awlen,
    input  logic [N_MASTERS-1:0][2:0]                         i_m_awsize,
    input  logic [N_MASTERS-1:0][1:0]                         i_m_awburst,
    input  logic [N_MASTERS-1:0]                              i_m_awvalid,
    output logic [N_MASTERS-1:0]                              o_m_awready,
    input  logic [N_MASTERS-1:0][AXI4_DATA_WIDTH-1:0]         i_m_wdata,
    input  logic [N_MASTERS-1:0][AXI4_DATA_WIDTH/8-1:0]       i_m_wstrb,
    input  logic [N_MASTERS-1:0]                              i_m_wlast,
    input  logic [N_MASTERS-1:0]                              i_m_wvalid,
    output logic [N_MASTERS-1:0]                              o_m_wready,
    output logic [N_MASTERS-1:0][AXI4_ID_WIDTH-1:0]           o_m_bid,
    output logic [N_MASTERS-1:0][1:0]                         o_m_bresp,
    output logic [N_MASTERS-1:0]                              o_m_bvalid,
    input  logic [N_MASTERS-1:0]                              i_m_bready,
    input  logic [N_MASTERS-1:0][AXI4_ID_WIDTH-1:0]           i_m_arid,
    input  logic [N_MASTERS-1:0][AXI4_ADDRESS_WIDTH-1:0]      i_m_araddr,
    input  logic [N_MASTERS-1:0][7:0]                         i_m_arlen,
    input  logic [N_MASTERS-1:0][2:0]                         i_m_arsize,
    input  logic [N_MASTERS-1:0][1:0]                         i_m_arburst,
    input  logic [N_MASTERS-1:0]                              i_m_arvalid,
    output logic [N_MASTERS-1:0]                              o_m_arready,
    output logic [N_MASTERS-1:0][AXI4_ID_WIDTH-1:0]           o_m_rid,
    output logic [N_MASTERS-1:0][AXI4_DATA_WIDTH-1:0]         o_m_rdata,
    output logic [N_MASTERS-1:0][1:0]                         o_m_rresp,
    output logic [N_MASTERS-1:0]                              o_m_rlast,
    output logic [N_MASTERS-1:0]                              o_m_rvalid,
    input  logic [N_MASTERS-1:0]                              i_m_rready,
    // downstream slave
    output logic [SID_W-1:0]                                  o_s_awid,
    output logic [AXI4_ADDRESS_WIDTH-1:0]                     o_s_awaddr,
    output logic [7:0]                                        o_s_awlen,
    output logic [2:0]                                        o_s_awsize,
    output logic [1:0]                                        o_s_awburst,
    output logic                                              o_s_awvalid,
    input  logic                                              i_s_awready,
    output logic [AXI4_DATA_WIDTH-1:0]                        o_s_wdata,
    output logic [AXI4_DATA_WIDTH/8-1:0]                      o_s_wstrb,
    output logic                                              o_s_wlast,
    output logic                                              o_s_wvalid,
    input  logic                                              i_s_wready,
    input  logic [SID_W-1:0]                                  i_s_bid,
    input  logic [1:0]                                        i_s_bresp,
    input  logic                                              i_s_bvalid,
    output logic                                              o_s_bready,
    output logic [SID_W-1:0]                                  o_s_arid,
    output logic [AXI4_ADDRESS_WIDTH-1:0]                     o_s_araddr,
    output logic [7:0]                                        o_s_arlen,
    output logic [2:0]                                        o_s_arsize,
    output logic [1:0]                                        o_s_arburst,
    output logic                                              o_s_arvalid,
    input  logic                                              i_s_arready,
    input  logic [SID_W-1:0]                                  i_s_rid,
    input  logic [AXI4_DATA_WIDTH-1:0]                        i_s_rdata,
    input  logic [1:0]                                        i_s_rresp,
    input  logic                                              i_s_rlast,
    input  logic                                              i_s_rvalid,
    output logic                                              o_s_rready
);

    localparam logic [MASTER_IDX_W-1:0] c_last_idx = MASTER_IDX_W'(N_MASTERS - 1);

    function automatic logic [MASTER_IDX_W-1:0] f_next(input logic [MASTER_IDX_W-1:0] g);
        return (g == c_last_idx) ? '0 : g + 1'b1;
    endfunction

    // Reset asserts asynchronously and releases synchronously to clk.
    logic r_rst_meta;
    logic r_rst_sync;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    aw_state_t               r_aw_state;
    ar_state_t               r_ar_state;
    logic [MASTER_IDX_W-1:0] r_aw_gnt;
    logic [MASTER_IDX_W-1:0] r_rr_aw;
    logic [MASTER_IDX_W-1:0] r_ar_gnt;
    logic [MASTER_IDX_W-1:0] r_rr_ar;
    logic [MASTER_IDX_W-1:0] w_aw_pick;
    logic [MASTER_IDX_W-1:0] w_ar_pick;
    logic                    w_aw_any;
    logic                    w_ar_any;
    logic                    w_aw_hs;
    logic                    w_w_done;
    logic                    w_ar_hs;

    axi4_rr_sel #(.N_MASTERS(N_MASTERS), .MASTER_IDX_W(MASTER_IDX_W)) u_aw_sel (
        .i_req   (i_m_awvalid),
        .i_ptr   (r_rr_aw),
        .o_grant (w_aw_pick),
        .o_valid (w_aw_any)
    );

    axi4_rr_sel #(.N_MASTERS(N_MASTERS), .MASTER_IDX_W(MASTER_IDX_W)) u_ar_sel (
        .i_req   (i_m_arvalid),
        .i_ptr   (r_rr_ar),
        .o_grant (w_ar_pick),
        .o_valid (w_ar_any)
    );

    assign w_aw_hs  = o_s_awvalid & i_s_awready;
    assign w_w_done = o_s_wvalid & i_s_wready & o_s_wlast;
    assign w_ar_hs  = o_s_arvalid & i_s_arready;

    always_ff @(posedge clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_aw_state <= AW_IDLE;
            r_aw_gnt   <= '0;
            r_rr_aw    <= '0;
        end else begin
            case (r_aw_state)
                AW_IDLE: if (w_aw_any) begin
                    r_aw_gnt   <= w_aw_pick;
                    r_aw_state <= AW_GRANT;
                end
                AW_GRANT: if (w_aw_hs) begin
                    r_rr_aw    <= f_next(r_aw_gnt);
                    r_aw_state <= W_BURST;
                end
                W_BURST: if (w_w_done) r_aw_state <= AW_IDLE;
                default: r_aw_state <= AW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_ar_state <= AR_IDLE;
            r_ar_gnt   <= '0;
            r_rr_ar    <= '0;
        end else begin
            case (r_ar_state)
                AR_IDLE: if (w_ar_any) begin
                    r_ar_gnt   <= w_ar_pick;
                    r_ar_state <= AR_GRANT;
                end
                AR_GRANT: if (w_ar_hs) begin
                    r_rr_ar    <= f_next(r_ar_gnt);
                    r_ar_state <= AR_IDLE;
                end
                default: r_ar_state <= AR_IDLE;
            endcase
        end
    end

    // Address/data payloads follow the grant; only the handshakes are gated.
    assign o_s_awid    = {r_aw_gnt, i_m_awid[r_aw_gnt]};
    assign o_s_awaddr  = i_m_awaddr[r_aw_gnt];
    assign o_s_awlen   = i_m_awlen[r_aw_gnt];
    assign o_s_awsize  = i_m_awsize[r_aw_gnt];
    assign o_s_awburst = i_m_awburst[r_aw_gnt];
    assign o_s_wdata   = i_m_wdata[r_aw_gnt];
    assign o_s_wstrb   = i_m_wstrb[r_aw_gnt];
    assign o_s_wlast   = i_m_wlast[r_aw_gnt];
    assign o_s_arid    = {r_ar_gnt, i_m_arid[r_ar_gnt]};
    assign o_s_araddr  = i_m_araddr[r_ar_gnt];
    assign o_s_arlen   = i_m_arlen[r_ar_gnt];
    assign o_s_arsize  = i_m_arsize[r_ar_gnt];
    assign o_s_arburst = i_m_arburst[r_ar_gnt];

    always_comb begin
        o_m_awready = '0;
        o_m_wready  = '0;
        o_m_arready = '0;
        o_s_awvalid = 1'b0;
        o_s_wvalid  = 1'b0;
        o_s_arvalid = 1'b0;
        if (r_aw_state == AW_GRANT) begin
            o_s_awvalid           = i_m_awvalid[r_aw_gnt];
            o_m_awready[r_aw_gnt] = i_s_awready;
        end
        if (r_aw_state == W_BURST) begin
            o_s_wvalid           = i_m_wvalid[r_aw_gnt];
            o_m_wready[r_aw_gnt] = i_s_wready;
        end
        if (r_ar_state == AR_GRANT) begin
            o_s_arvalid           = i_m_arvalid[r_ar_gnt];
            o_m_arready[r_ar_gnt] = i_s_arready;
        end
    end

    logic [MASTER_IDX_W-1:0] w_b_sel;
    logic [MASTER_IDX_W-1:0] w_r_sel;
    logic                    w_b_oor;
    logic                    w_r_oor;

    assign w_b_sel = i_s_bid[SID_W-1 -: MASTER_IDX_W];
    assign w_r_sel = i_s_rid[SID_W-1 -: MASTER_IDX_W];

    generate
        if ((N_MASTERS & (N_MASTERS - 1)) == 0) begin : g_pow2
            assign w_b_oor = 1'b0;
            assign w_r_oor = 1'b0;
        end else begin : g_npow2
            assign w_b_oor = (32'(w_b_sel) >= N_MASTERS);
            assign w_r_oor = (32'(w_r_sel) >= N_MASTERS);
        end
    endgenerate

    // Responses to a nonexistent master are accepted and dropped.
    always_comb begin
        o_m_bvalid = '0;
        o_m_rvalid = '0;
        o_s_bready = 1'b0;
        o_s_rready = 1'b0;
        if (r_rst_sync) begin
            if (w_b_oor) begin
                o_s_bready = 1'b1;
            end else begin
                o_m_bvalid[w_b_sel] = i_s_bvalid;
                o_s_bready          = i_m_bready[w_b_sel];
            end
            if (w_r_oor) begin
                o_s_rready = 1'b1;
            end else begin
                o_m_rvalid[w_r_sel] = i_s_rvalid;
                o_s_rready          = i_m_rready[w_r_sel];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_resp_bcast
            assign o_m_bid[gi]   = i_s_bid[AXI4_ID_WIDTH-1:0];
            assign o_m_bresp[gi] = i_s_bresp;
            assign o_m_rid[gi]   = i_s_rid[AXI4_ID_WIDTH-1:0];
            assign o_m_rdata[gi] = i_s_rdata;
            assign o_m_rresp[gi] = i_s_rresp;
            assign o_m_rlast[gi] = i_s_rlast;
        end
    endgenerate

    a_b_idx_range: assert property (@(posedge clk) disable iff (!r_rst_sync)
        !(i_s_bvalid && w_b_oor))
        else $error("B response addressed to nonexistent master %0d", w_b_sel);

    a_r_idx_range: assert property (@(posedge clk) disable iff (!r_rst_sync)
        !(i_s_rvalid && w_r_oor))
        else $error("R response addressed to nonexistent master %0d", w_r_sel);

endmodule

`default_nettype wire

// File: tb/tb_axi4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_rr_arbiter
// Description : Directed self-checking bench for axi4_rr_arbiter (2 masters).
// Revision    : 1.0  initial release
// ============================================================================
module tb_axi4_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int IW = 4;
    localparam int SW = 5;

    logic clk = 1'b0;
    logic rstn;

    logic [N-1:0][IW-1:0]   m_awid, m_arid, m_bid, m_rid;
    logic [N-1:0][AW-1:0]   m_awaddr, m_araddr;
    logic [N-1:0][7:0]      m_awlen, m_arlen;
    logic [N-1:0][2:0]      m_awsize, m_arsize;
    logic [N-1:0][1:0]      m_awburst, m_arburst, m_bresp, m_rresp;
    logic [N-1:0]           m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic [N-1:0]           m_bvalid, m_bready, m_arvalid, m_arready;
    logic [N-1:0]           m_rlast, m_rvalid, m_rready;
    logic [N-1:0][DW-1:0]   m_wdata, m_rdata;
    logic [N-1:0][DW/8-1:0] m_wstrb;

    logic [SW-1:0]   s_awid, s_arid, s_bid, s_rid;
    logic [AW-1:0]   s_awaddr, s_araddr;
    logic [7:0]      s_awlen, s_arlen;
    logic [2:0]      s_awsize, s_arsize;
    logic [1:0]      s_awburst, s_arburst, s_bresp, s_rresp;
    logic            s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic            s_bvalid, s_bready, s_arvalid, s_arready;
    logic            s_rlast, s_rvalid, s_rready;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic [DW/8-1:0] s_wstrb;

    int n_checks = 0;
    int n_errors = 0;

    axi4_rr_arbiter #(
        .N_MASTERS(N), .AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_m_awid(m_awid), .i_m_awaddr(m_awaddr), .i_m_awlen(m_awlen), .i_m_awsize(m_awsize),
        .i_m_awburst(m_awburst), .i_m_awvalid(m_awvalid), .o_m_awready(m_awready),
        .i_m_wdata(m_wdata), .i_m_wstrb(m_wstrb), .i_m_wlast(m_wlast), .i_m_wvalid(m_wvalid),
        .o_m_wready(m_wready),
        .o_m_bid(m_bid), .o_m_bresp(m_bresp), .o_m_bvalid(m_bvalid), .i_m_bready(m_bready),
        .i_m_arid(m_arid), .i_m_araddr(m_araddr), .i_m_arlen(m_arlen), .i_m_arsize(m_arsize),
        .i_m_arburst(m_arburst), .i_m_arvalid(m_arvalid), .o_m_arready(m_arready),
        .o_m_rid(m_rid), .o_m_rdata(m_rdata), .o_m_rresp(m_rresp), .o_m_rlast(m_rlast),
        .o_m_rvalid(m_rvalid), .i_m_rready(m_rready),
        .o_s_awid(s_awid), .o_s_awaddr(s_awaddr), .o_s_awlen(s_awlen), .o_s_awsize(s_awsize),
        .o_s_awburst(s_awburst), .o_s_awvalid(s_awvalid), .i_s_awready(s_awready),
        .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb), .o_s_wlast(s_wlast), .o_s_wvalid(s_wvalid),
        .i_s_wready(s_wready),
        .i_s_bid(s_bid), .i_s_bresp(s_bresp), .i_s_bvalid(s_bvalid), .o_s_bready(s_bready),
        .o_s_arid(s_arid), .o_s_araddr(s_araddr), .o_s_arlen(s_arlen), .o_s_arsize(s_arsize),
        .o_s_arburst(s_arburst), .o_s_arvalid(s_arvalid), .i_s_arready(s_arready),
        .i_s_rid(s_rid), .i_s_rdata(s_rdata), .i_s_rresp(s_rresp), .i_s_rlast(s_rlast),
        .i_s_rvalid(s_rvalid), .o_s_rready(s_rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0; m_awvalid = '0;
        m_wdata = '0; m_wstrb = '1; m_wlast = '0; m_wvalid = '0; m_bready = '0;
        m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0; m_arvalid = '0;
        m_rready = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bid = '0; s_bresp = '0; s_bvalid = 1'b0;
        s_arready = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        repeat (3) step();
    endtask

    task automatic wait_aw(input logic exp_m, input string tag);
        for (int k = 0; k < 20 && !s_awvalid; k++) step();
        check({tag, "_awvalid"}, s_awvalid, 1'b1);
        check({tag, "_awid_master"}, s_awid[4], exp_m);
    endtask

    task automatic wait_ar(input logic exp_m, input string tag);
        for (int k = 0; k < 20 && !s_arvalid; k++) step();
        check({tag, "_arvalid"}, s_arvalid, 1'b1);
        check({tag, "_arid_master"}, s_arid[4], exp_m);
    endtask

    // Call right after the AW handshake edge; drives and checks each beat.
    task automatic w_burst(input int m, input int beats, input string tag);
        logic [127:0] d;
        for (int b = 0; b < beats; b++) begin
            d = 128'(32'hA500_0000 + m * 256 + b);
            m_wvalid[m] = 1'b1;
            m_wdata[m]  = d;
            m_wlast[m]  = (b == beats - 1);
            #1;
            check({tag, "_wvalid"}, s_wvalid, 1'b1);
            check({tag, "_wdata"}, s_wdata, d);
            check({tag, "_wlast"}, s_wlast, (b == beats - 1));
            step();
        end
        m_wvalid[m] = 1'b0;
        m_wlast[m]  = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rstn = 1'b0;
        // Outputs held quiet while in reset even with traffic present.
        m_awvalid = 2'b11; m_arvalid = 2'b11; m_wvalid = 2'b11;
        s_bvalid = 1'b1; s_rvalid = 1'b1; m_bready = 2'b11; m_rready = 2'b11;
        step();
        check("rst_m_awready", m_awready, 2'b00);
        check("rst_s_awvalid", s_awvalid, 1'b0);
        check("rst_s_wvalid", s_wvalid, 1'b0);
        check("rst_s_arvalid", s_arvalid, 1'b0);
        check("rst_m_bvalid", m_bvalid, 2'b00);
        check("rst_m_rvalid", m_rvalid, 2'b00);
        check("rst_s_bready", s_bready, 1'b0);
        check("rst_s_rready", s_rready, 1'b0);
        clear_inputs();
        do_reset();

        // Single master: ID 3, 4-beat burst, W presented early must stall.
        s_awready = 1'b1; s_wready = 1'b1;
        m_awid[0] = 4'h3; m_awaddr[0] = 32'h1000; m_awlen[0] = 8'd3; m_awvalid[0] = 1'b1;
        m_wvalid[0] = 1'b1;
        #1;
        check("single_idle_awvalid", s_awvalid, 1'b0);
        step();
        check("single_awvalid", s_awvalid, 1'b1);
        check("single_awid", s_awid, 5'h03);
        check("single_awaddr", s_awaddr, 32'h1000);
        check("single_awlen", s_awlen, 8'd3);
        check("single_awready", m_awready, 2'b01);
        check("single_w_stall_s", s_wvalid, 1'b0);
        check("single_w_stall_m", m_wready, 2'b00);
        step();
        m_awvalid[0] = 1'b0;
        w_burst(0, 4, "single");
        s_bid = 5'h03; s_bvalid = 1'b1; m_bready = 2'b01;
        #1;
        check("single_bvalid", m_bvalid, 2'b01);
        check("single_bid", m_bid[0], 4'h3);
        check("single_bready", s_bready, 1'b1);
        m_bready = 2'b10;
        #1;
        check("single_bready_m0_low", s_bready, 1'b0);
        step();
        s_bvalid = 1'b0; m_bready = '0;

        // Contention from pointer 0: grants alternate m0, m1, m0, m1.
        clear_inputs();
        do_reset();
        s_awready = 1'b1; s_wready = 1'b1;
        m_awid[0] = 4'h1; m_awid[1] = 4'h2; m_awlen = {8'd1, 8'd1};
        m_awvalid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_aw(1'(t % 2), "cont");
            check("cont_awready", m_awready, (t % 2) ? 2'b10 : 2'b01);
            step();
            if (t == 3) m_awvalid = 2'b00;
            w_burst(t % 2, 2, "cont");
        end

        // Backpressure: grant stays on m0 while m1 waits.
        s_awready = 1'b0;
        m_awaddr[0] = 32'hA000; m_awlen[0] = 8'd0; m_awvalid = 2'b01;
        wait_aw(1'b0, "bp");
        m_awaddr[1] = 32'hB000; m_awid[1] = 4'h5; m_awlen[1] = 8'd1; m_awvalid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_awaddr", s_awaddr, 32'hA000);
            check("bp_awid", s_awid, 5'h01);
            check("bp_m_awready", m_awready, 2'b00);
            step();
        end
        s_awready = 1'b1;
        #1;
        check("bp_release_awready", m_awready, 2'b01);
        step();
        m_awvalid[0] = 1'b0;
        w_burst(0, 1, "bp");

        // m0 read (ARLEN 7) alongside m1 write; R and B return together.
        s_arready = 1'b1;
        m_arid[0] = 4'h6; m_araddr[0] = 32'h2000; m_arlen[0] = 8'd7; m_arvalid[0] = 1'b1;
        wait_aw(1'b1, "il");
        check("il_awaddr", s_awaddr, 32'hB000);
        check("il_arvalid", s_arvalid, 1'b1);
        check("il_arid", s_arid, 5'h06);
        check("il_arlen", s_arlen, 8'd7);
        check("il_arready", m_arready, 2'b01);
        step();
        m_awvalid[1] = 1'b0; m_arvalid[0] = 1'b0;
        w_burst(1, 2, "il");
        m_bready = 2'b11; m_rready = 2'b11;
        s_bvalid = 1'b1; s_bid = 5'h15; s_rvalid = 1'b1; s_rid = 5'h06;
        for (int b = 0; b < 8; b++) begin
            s_rdata = 128'(32'hD000 + b);
            s_rlast = (b == 7);
            #1;
            check("il_rvalid", m_rvalid, 2'b01);
            check("il_rdata", m_rdata[0], 128'(32'hD000 + b));
            check("il_rid", m_rid[0], 4'h6);
            check("il_rlast", m_rlast[0], (b == 7));
            check("il_rready", s_rready, 1'b1);
            if (b == 0) begin
                check("il_bvalid", m_bvalid, 2'b10);
                check("il_bid", m_bid[1], 4'h5);
                check("il_bready", s_bready, 1'b1);
            end
            step();
            s_bvalid = 1'b0;
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;

        // Out-of-order read return.
        m_arid[0] = 4'h1; m_arlen[0] = 8'd0; m_arvalid = 2'b01;
        wait_ar(1'b0, "ooo0");
        check("ooo0_arid", s_arid, 5'h01);
        step();
        m_arid[1] = 4'h2; m_arvalid = 2'b10;
        wait_ar(1'b1, "ooo1");
        check("ooo1_arid", s_arid, 5'h12);
        step();
        m_arvalid = 2'b00;
        s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 5'h12;
        #1;
        check("ooo_first_rvalid", m_rvalid, 2'b10);
        check("ooo_first_rid", m_rid[1], 4'h2);
        step();
        s_rid = 5'h01;
        #1;
        check("ooo_second_rvalid", m_rvalid, 2'b01);
        check("ooo_second_rid", m_rid[0], 4'h1);
        step();
        s_rvalid = 1'b0; s_rlast = 1'b0;

        // Reset asserted during beat 2 of 4.
        m_awid[0] = 4'h3; m_awlen[0] = 8'd3; m_awvalid = 2'b01;
        wait_aw(1'b0, "mid");
        step();
        m_awvalid = 2'b00;
        m_wvalid[0] = 1'b1; m_wlast[0] = 1'b0;
        step();
        s_bvalid = 1'b1; s_bid = 5'h03; s_rvalid = 1'b1; s_rid = 5'h03;
        m_bready = 2'b11; m_rready = 2'b11;
        #1;
        check("mid_beat2_wvalid", s_wvalid, 1'b1);
        rstn = 1'b0;
        #1;
        check("mid_rst_wvalid", s_wvalid, 1'b0);
        check("mid_rst_wready", m_wready, 2'b00);
        check("mid_rst_awvalid", s_awvalid, 1'b0);
        check("mid_rst_bvalid", m_bvalid, 2'b00);
        check("mid_rst_rvalid", m_rvalid, 2'b00);
        check("mid_rst_bready", s_bready, 1'b0);
        check("mid_rst_rready", s_rready, 1'b0);
        clear_inputs();
        step();
        rstn = 1'b1;
        repeat (3) step();
        s_awready = 1'b1; s_wready = 1'b1;
        m_wvalid = 2'b11;
        #1;
        check("post_rst_idle_wready", m_wready, 2'b00);
        m_wvalid = 2'b00;
        m_awlen = '0; m_awid[1] = 4'h7; m_awvalid = 2'b11;
        wait_aw(1'b0, "post_rst_m0");
        step();
        m_awvalid[0] = 1'b0;
        w_burst(0, 1, "post_rst_m0");
        wait_aw(1'b1, "post_rst_m1");
        check("post_rst_m1_awid", s_awid, 5'h17);
        step();
        m_awvalid = 2'b00;
        w_burst(1, 1, "post_rst_m1");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
